// File: rtl/sigmoid_act_pipe_if.sv
// Stream and ROM-side signals of the sigmoid activation stage.
// Handshake: a word moves on a rising edge where valid && ready; valid, once raised, holds with stable data until that edge.
interface sigmoid_act_pipe_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [5:0]        rom_addr;
    logic [15:0]       rom_data;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_data;
    logic [15:0]       sat_count;

    modport master (
        output in_valid, in_data, rom_data, out_ready,
        input  in_ready, rom_addr, out_valid, out_data, sat_count
    );

    modport slave (
        input  in_valid, in_data, rom_data, out_ready,
        output in_ready, rom_addr, out_valid, out_data, sat_count
    );
endinterface

// File: rtl/sigmoid_act_pipe.sv
// Two-stage sigmoid activation: S1 folds |x| into a saturated ROM address,
// S2 reads the half-range ROM and rebuilds negative inputs as 1 - sigmoid(|x|).
module sigmoid_act_pipe #(
    parameter int DATA_W     = 16,
    parameter int STEP_SHIFT = 5,
    parameter int MAX_IDX    = 48,
    parameter int ONE_Q      = 256
) (
    input logic              clk,
    input logic              rst,
    sigmoid_act_pipe_if.slave bus
);
    logic              s1_valid;
    logic              s1_neg;
    logic              s2_valid;
    logic              s2_free;
    logic              s1_adv;
    logic              accept;
    logic [DATA_W:0]   in_ext;
    logic [DATA_W:0]   mag;
    logic [DATA_W:0]   idx;
    logic              sat;
    logic [5:0]        addr_next;
    logic [7:0]        r;
    logic [8:0]        res;

    // One extra bit so that |0x8000| = 0x8000 does not wrap.
    assign in_ext    = {bus.in_data[DATA_W-1], bus.in_data};
    assign mag       = bus.in_data[DATA_W-1] ? (~in_ext + 1'b1) : in_ext;
    assign idx       = mag >> STEP_SHIFT;
    assign sat       = idx > (DATA_W+1)'(MAX_IDX);
    assign addr_next = sat ? 6'(MAX_IDX) : idx[5:0];

    assign r   = bus.rom_data[7:0];
    assign res = s1_neg ? (9'(ONE_Q) - {1'b0, r}) : {1'b0, r};

    assign s2_free      = !s2_valid || bus.out_ready;
    assign s1_adv       = s1_valid && s2_free;
    assign bus.in_ready = !s1_valid || s2_free;
    assign accept       = bus.in_valid && bus.in_ready;
    assign bus.out_valid = s2_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_neg        <= 1'b0;
            s2_valid      <= 1'b0;
            bus.rom_addr  <= '0;
            bus.out_data  <= '0;
            bus.sat_count <= '0;
        end else begin
            if (accept) begin
                bus.rom_addr  <= addr_next;
                s1_neg        <= bus.in_data[DATA_W-1];
                bus.sat_count <= bus.sat_count + {15'b0, sat};
            end

            if (accept)
                s1_valid <= 1'b1;
            else if (s1_adv)
                s1_valid <= 1'b0;

            // S2 reloads whenever S1 advances, so a drain only clears it when S1 is empty.
            if (s1_adv) begin
                bus.out_data <= {7'b0, res};
                s2_valid     <= 1'b1;
            end else if (s2_valid && bus.out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sigmoid_act_pipe.sv
// Directed and random checks of sigmoid_act_pipe against a table-driven reference.
module tb_sigmoid_act_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sigmoid_act_pipe_if #(.DATA_W(16)) bus();

    sigmoid_act_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // round(256 * sigmoid(k * 0.125)), k = 0..48
    logic [7:0] tbl [0:48] = '{
        8'd128, 8'd136, 8'd144, 8'd152, 8'd159, 8'd167, 8'd174, 8'd181,
        8'd187, 8'd193, 8'd199, 8'd204, 8'd209, 8'd214, 8'd218, 8'd222,
        8'd225, 8'd229, 8'd232, 8'd234, 8'd237, 8'd239, 8'd241, 8'd242,
        8'd244, 8'd245, 8'd246, 8'd248, 8'd248, 8'd249, 8'd250, 8'd251,
        8'd251, 8'd252, 8'd252, 8'd253, 8'd253, 8'd254, 8'd254, 8'd254,
        8'd254, 8'd254, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255,
        8'd255
    };

    // Upper ROM bits carry junk so that only [7:0] may influence the result.
    assign bus.rom_data = (bus.rom_addr <= 6'd48) ? {8'hA5, tbl[bus.rom_addr]} : 16'hDEAD;

    int          total = 0;
    int          bad   = 0;
    int          n_out = 0;
    logic [15:0] exp_q[$];
    logic [15:0] sat_exp = 16'd0;
    bit          held = 1'b0;
    logic [15:0] held_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic int ref_idx(input logic [15:0] x);
        int v;
        int m;
        v = int'($signed(x));
        m = (v < 0) ? -v : v;
        return m >>> 5;
    endfunction

    function automatic logic [15:0] model(input logic [15:0] x);
        int i;
        i = ref_idx(x);
        if (i > 48) i = 48;
        if (x[15]) return 16'(256 - int'(tbl[i]));
        return {8'h00, tbl[i]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
        chk(tag, exp_q.size(), 0);
    endtask

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_data", bus.out_data, held_data);
            end
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                chk("sb_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("sb_data", bus.out_data, exp_q.pop_front());
            end
            held      = bus.out_valid && !bus.out_ready;
            held_data = bus.out_data;
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.in_data));
                if (ref_idx(bus.in_data) > 48) sat_exp++;
            end
        end
    end

    logic [15:0] sat_in  [5] = '{16'h05FF, 16'h0600, 16'h0620, 16'h7FFF, 16'h8000};
    logic [5:0]  sat_adr [5] = '{6'd47, 6'd48, 6'd48, 6'd48, 6'd48};
    logic [15:0] sat_out [5] = '{16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 16'h0001};
    logic [15:0] bp_in   [5] = '{16'h0040, 16'h0080, 16'h00C0, 16'h0100, 16'h0140};

    initial begin
        int k;
        int n0;
        int acc;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
        sat_exp = 16'd0;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 16'h0000);
        chk("rst_rom_addr", bus.rom_addr, 0);
        chk("rst_sat", bus.sat_count, 0);
        chk("rst_in_ready", bus.in_ready, 1);

        // Basic stream and latency
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0000;
        tick();
        chk("lat_addr0", bus.rom_addr, 0);
        chk("lat_valid0", bus.out_valid, 0);
        bus.in_data = 16'h0020;
        tick();
        chk("lat_valid1", bus.out_valid, 1);
        chk("stream_0000", bus.out_data, 16'h0080);
        chk("addr_0020", bus.rom_addr, 1);
        bus.in_data = 16'hFFE0;
        tick();
        chk("stream_valid", bus.out_valid, 1);
        chk("stream_0020", bus.out_data, 16'h0088);
        bus.in_valid = 1'b0;
        tick();
        chk("stream_valid2", bus.out_valid, 1);
        chk("stream_ffe0", bus.out_data, 16'h0078);
        tick();
        chk("stream_idle", bus.out_valid, 0);

        // +1.0 and -1.0
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0100;
        tick();
        chk("addr_p1", bus.rom_addr, 8);
        bus.in_data = 16'hFF00;
        tick();
        chk("addr_m1", bus.rom_addr, 8);
        chk("out_p1", bus.out_data, 16'h00BB);
        bus.in_valid = 1'b0;
        tick();
        chk("out_m1", bus.out_data, 16'h0045);
        tick();

        // Saturation boundary
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = (i < 5);
            if (i < 5) bus.in_data = sat_in[i];
            tick();
            if (i < 5) chk("sat_addr", bus.rom_addr, sat_adr[i]);
            if (i > 0) chk("sat_out", bus.out_data, sat_out[i-1]);
        end
        bus.in_valid = 1'b0;
        tick();
        chk("sat_count", bus.sat_count, 3);

        // Backpressure
        n0 = n_out;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = bp_in[0];
        tick();
        bus.in_data = bp_in[1];
        tick();
        bus.in_data = bp_in[2];
        #1;
        chk("bp_in_ready", bus.in_ready, 0);
        chk("bp_valid", bus.out_valid, 1);
        chk("bp_data", bus.out_data, 16'h0090);
        repeat (3) begin
            tick();
            chk("bp_stall_ready", bus.in_ready, 0);
            chk("bp_stall_data", bus.out_data, 16'h0090);
        end
        bus.out_ready = 1'b1;
        k = 2;
        for (int c = 0; c < 50 && k < 5; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = bp_in[k];
            #1;
            if (bus.in_ready) k++;
            tick();
        end
        bus.in_valid = 1'b0;
        chk("bp_sent", k, 5);
        drain("bp_drain");
        chk("bp_count", n_out - n0, 5);

        // Reset with samples in flight
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h0620;
        tick();
        bus.in_data = 16'h0100;
        tick();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        sat_exp = 16'd0;
        n0 = n_out;
        chk("mrst_valid", bus.out_valid, 0);
        chk("mrst_sat", bus.sat_count, 0);
        bus.out_ready = 1'b1;
        repeat (3) begin
            tick();
            chk("mrst_no_stale", bus.out_valid, 0);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0040;
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("mrst_new_valid", bus.out_valid, 1);
        chk("mrst_new_data", bus.out_data, 16'h0090);
        tick();
        chk("mrst_count", n_out - n0, 1);

        // Random traffic
        acc = 0;
        for (int c = 0; c < 60000 && acc < 10000; c++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = ($urandom_range(0, 1) != 0) ? 16'($urandom)
                                                        : 16'($signed(16'($urandom_range(0, 4000))) - 16'sd2000);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.in_valid && bus.in_ready) acc++;
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("rnd_accepted", acc, 10000);
        drain("rnd_drain");
        chk("rnd_sat", bus.sat_count, sat_exp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
